// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: 32-bit add through one reused 4-bit lookahead slice, one nibble per clock.
// Define NIBBLE_SUB_EN to add the op port (op=1 computes a-b).
module nibble_serial_adder #(
  parameter int NIBBLES = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   ci,
`ifdef NIBBLE_SUB_EN
  input  logic                   op,
`endif
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   co,
  output logic                   ov
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, next;
  logic [W-1:0] a_r, b_r, shifted;
  logic [W-5:0] work;
  logic [CW-1:0] cnt;
  logic carry, last;
  logic [3:0] np, ng, nsum;
  logic [4:0] c;
  // Operands shift right each cycle so the active nibble always sits in bits [3:0].
  assign np = a_r[3:0] | b_r[3:0];
  assign ng = a_r[3:0] & b_r[3:0];
  assign c[0] = carry;
  assign c[1] = ng[0] | np[0] & c[0];
  assign c[2] = ng[1] | np[1] & ng[0] | np[1] & np[0] & c[0];
  assign c[3] = ng[2] | np[2] & ng[1] | np[2] & np[1] & ng[0] | np[2] & np[1] & np[0] & c[0];
  assign c[4] = ng[3] | np[3] & ng[2] | np[3] & np[2] & ng[1] | np[3] & np[2] & np[1] & ng[0]
              | np[3] & np[2] & np[1] & np[0] & c[0];
  assign nsum = np ^ ng ^ c[3:0];
  assign shifted = {nsum, work};
  assign last = cnt == CW'(NIBBLES - 1);
  assign s_ready = state == IDLE;
  assign m_valid = state == DONE;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = s_valid ? CALC : IDLE;
      CALC:    next = last ? DONE : CALC;
      DONE:    next = m_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      work  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      ov    <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && s_valid) begin
        a_r   <= a;
        cnt   <= '0;
`ifdef NIBBLE_SUB_EN
        b_r   <= op ? ~b : b;
        carry <= op | ci;
`else
        b_r   <= b;
        carry <= ci;
`endif
      end
      if (state == CALC) begin
        a_r   <= a_r >> 4;
        b_r   <= b_r >> 4;
        work  <= shifted[W-1:4];
        carry <= c[4];
        cnt   <= last ? '0 : cnt + CW'(1);
        if (last) begin
          s  <= shifted;
          co <= c[4];
          ov <= c[3] ^ c[4];
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vectors for nibble_serial_adder (default build, add only).
module tb_nibble_serial_adder;
  logic clk, reset_n, s_valid, s_ready, ci, m_valid, m_ready, co, ov;
  logic [31:0] a, b, s, prev_s;
  int errors, checks, n;
  nibble_serial_adder dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .a(a), .b(b), .ci(ci), .m_valid(m_valid), .m_ready(m_ready),
    .s(s), .co(co), .ov(ov)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask
  task automatic wait_result();
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tci, input logic [31:0] es, input logic eco, input logic eov);
    @(negedge clk);
    a = ta; b = tb_v; ci = tci; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    check({tag, "_busy"}, s_ready, 0);
    check({tag, "_held"}, s, prev_s);
    wait_result();
    check({tag, "_lat"}, n, 8);
    check({tag, "_s"}, s, es);
    check({tag, "_co"}, co, eco);
    check({tag, "_ov"}, ov, eov);
    @(negedge clk);
    check({tag, "_idle"}, {m_valid, s_ready}, 2'b01);
    check({tag, "_keep"}, s, es);
    prev_s = es;
  endtask
  initial begin
    errors = 0; checks = 0; prev_s = 0;
    reset_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; a = 0; b = 0; ci = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", s_ready, 1);
    check("rst_valid", m_valid, 0);
    check("rst_s", s, 0);
    check("rst_coov", {co, ov}, 0);
    run_op("simple", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("mixed", 32'hF0F0_F0F0, 32'h1010_1010, 1'b0, 32'h0101_0100, 1'b1, 1'b0);
    run_op("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run_op("nib", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 32'h1010_1010, 1'b0, 1'b0);
    // backpressure: result held, new request ignored until back in IDLE
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; ci = 1'b0; s_valid = 1'b1; m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    wait_result();
    check("bp_lat", n, 8);
    check("bp_s", s, 32'h2345_6789);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; ci = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stable_s", s, 32'h2345_6789);
      check("bp_stable_hs", {m_valid, s_ready, co, ov}, 4'b1000);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {m_valid, s_ready}, 2'b01);
    @(negedge clk);
    s_valid = 1'b0;
    check("bp_accept", s_ready, 0);
    wait_result();
    check("bp2_lat", n, 8);
    check("bp2_s", s, 32'hFFFF_FFFE);
    check("bp2_coov", {co, ov}, 2'b10);
    prev_s = 32'hFFFF_FFFE;
    // reset in the middle of CALC
    @(negedge clk);
    a = 32'h7FFF_FFFF; b = 32'h0000_0001; ci = 1'b0; s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_hs", {m_valid, s_ready}, 2'b01);
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_out", {s, co, ov}, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_valid) n++;
    end
    check("mid_rst_novalid", n, 0);
    prev_s = 0;
    run_op("recover", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle 32-bit adder that feeds operands, one 4-bit nibble per clock, through the team's 4-bit carry-lookahead slice (`clb` logic). A registered carry links successive nibbles. The block sits between an operand source and a result consumer, with valid/ready handshakes on both sides. It trades latency for area: one 4-bit lookahead stage is reused `NIBBLES` times instead of instantiating a full-width adder.

## Interface
- `NIBBLES`, default 8: number of 4-bit slices; operand width W = 4*NIBBLES.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: operand set valid.
- `s_ready` out 1: block can accept operands.
- `a` in W: operand A.
- `b` in W: operand B.
- `ci` in 1: carry-in into nibble 0.
- `op` in 1: present only with `NIBBLE_SUB_EN`; 0 = add, 1 = subtract.
- `m_valid` out 1: result valid.
- `m_ready` in 1: consumer accepts result.
- `s` out W: sum.
- `co` out 1: carry-out of the top nibble.
- `ov` out 1: signed overflow.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `s_ready`=1.
  - When `s_valid`=1: latch `a`, `b` and `ci` into operand registers, clear nibble counter `cnt` to 0 and the carry register to the latched carry-in, then go to CALC.
- CALC:
  - `s_ready`=0, `m_valid`=0.
  - Each cycle: a 4-bit lookahead computes nibble `cnt` from A[4cnt+3:4cnt], B[4cnt+3:4cnt] and the carry register. Per-bit sum is p^g^carry, with p = a|b and g = a&b as in `clb`.
  - The sum nibble is written into a working register and the carry register takes the nibble's `co`.
  - When `cnt`=NIBBLES-1: also capture that nibble's `c3` (carry into the MSB). Then transfer the working sum to `s`, set `co` = nibble co and `ov` = c3 ^ co, and go to DONE. Otherwise `cnt` increments.
- DONE:
  - `m_valid`=1; `s`, `co` and `ov` are held stable.
  - When `m_ready`=1: go to IDLE.
- `s`, `co` and `ov` change only on the CALC→DONE edge and hold their value through IDLE and CALC of the next operation.
- `s_valid` while `s_ready`=0 is ignored; the source must hold its request.
- Arithmetic is modulo 2^W; `co` is the unsigned carry; `ov` is two's-complement overflow.
- `reset_n` low at any time (including mid-CALC) aborts the operation immediately: the state returns to IDLE and no partial result is presented.

## Timing
- Reset values: state IDLE, `s_ready`=1, `m_valid`=0, `s`=0, `co`=0, `ov`=0, `cnt`=0, carry register 0.
- `s_ready` and `m_valid` are decoded directly from the state register (no combinational path from `s_valid`/`m_ready`).
- Latency: operands accepted on edge 0; `m_valid` rises after edge NIBBLES (8 cycles by default).
- Throughput: with `m_ready` held at 1, DONE lasts one cycle and `s_ready` returns at edge NIBBLES+1. Peak rate is one operation per NIBBLES+2 cycles.
- Carry crosses nibble boundaries only through the carry register, one nibble per cycle; no combinational path spans more than 4 bits.

## Configuration
- `NIBBLE_SUB_EN` defined:
  - Port `op` exists and is latched with the operands.
  - op=1: B is replaced by ~B and carry-in is forced to 1 (`ci` ignored), giving A-B. In this mode `co`=1 means no borrow.
  - op=0: add, identical to the build without the macro.
- `NIBBLE_SUB_EN` undefined: no `op` port; the block always adds A+B+ci.

## Test plan
- Reset: assert `reset_n`=0, then release → `s_ready`=1, `m_valid`=0, `s`=0x00000000, `co`=0, `ov`=0.
- Simple add: a=0x00000001, b=0x00000001, ci=0 → `m_valid` high 8 cycles after accept; `s`=0x00000002, `co`=0, `ov`=0.
- Full ripple: a=0xFFFFFFFF, b=0x00000000, ci=1 → `s`=0x00000000, `co`=1, `ov`=0 (carry propagates through all 8 nibbles).
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, ci=0 → `s`=0x80000000, `co`=0, `ov`=1.
- Backpressure plus mid-op reset:
  - Hold `m_ready`=0 for 5 cycles in DONE → `s`/`co`/`ov` stable, `s_ready`=0, and a new `s_valid` is not accepted until one cycle after `m_ready`=1.
  - Separately, pulse `reset_n` low at cnt=3 → IDLE, `m_valid` never asserts.
- `NIBBLE_SUB_EN` build: a=0x00000005, b=0x00000007, op=1 → `s`=0xFFFFFFFE, `co`=0, `ov`=0; a=0x80000000, b=0x00000001, op=1 → `s`=0x7FFFFFFF, `co`=1, `ov`=1.
